// File: rtl/softmax_row_gather.sv
// Gathers narrow input beats into one padded row for softmax_approx, tracking the
// signed row maximum as lanes arrive and force-closing rows that fill every lane.
module softmax_row_gather #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       LANES      = 64,
  parameter int unsigned       BEAT_LANES = 4,
  parameter logic [DATA_W-1:0] PAD        = 16'h8000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [BEAT_LANES*DATA_W-1:0] i_data,
  input  logic [BEAT_LANES-1:0]        i_keep,
  input  logic                         i_last,
  input  logic [3:0]                   i_length_mode,
  output logic                         o_valid,
  output logic [LANES*DATA_W-1:0]      o_x_flat,
  output logic [3:0]                   o_length_mode,
  output logic [$clog2(LANES+1)-1:0]   o_row_len,
  output logic [DATA_W-1:0]            o_row_max,
  output logic                         o_overflow
);

  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam int unsigned IDX_W = $clog2(LANES);

  typedef enum logic {StIdle, StFill} state_e;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_buf [LANES];
  logic [DATA_W-1:0]   w_buf_nxt [LANES];
  logic [DATA_W-1:0]   r_max, w_max_nxt;
  logic [3:0]          r_mode, w_mode;
  logic [CNT_W:0]      w_sum;
  logic [DATA_W-1:0]   w_lane;
  logic                w_have, w_accept, w_full, w_close, w_emit, w_ovf;
  logic [LANES*DATA_W-1:0] w_flat;

  assign o_ready = i_en;

  always_comb begin
    w_accept  = i_valid && i_en;
    w_mode    = (r_state == StIdle) ? i_length_mode : r_mode;
    w_buf_nxt = r_buf;
    w_max_nxt = r_max;
    w_sum     = {1'b0, r_cnt};
    w_have    = (r_cnt != '0);
    w_lane    = '0;
    // w_sum doubles as the write pointer; lanes past the last slot are dropped
    for (int unsigned k = 0; k < BEAT_LANES; k++) begin
      w_lane = i_data[k*DATA_W +: DATA_W];
      if (i_keep[k] && (w_sum < (CNT_W+1)'(LANES))) begin
        w_buf_nxt[w_sum[IDX_W-1:0]] = w_lane;
        if (!w_have || ($signed(w_lane) > $signed(w_max_nxt))) begin
          w_max_nxt = w_lane;
        end
        w_have = 1'b1;
        w_sum  = w_sum + (CNT_W+1)'(1);
      end
    end
    w_cnt_nxt = w_sum[CNT_W-1:0];
    w_full    = (w_sum == (CNT_W+1)'(LANES));
    w_close   = i_last || w_full;
    w_emit    = w_accept && w_close && (w_sum != '0);
    w_ovf     = w_full && !i_last;

    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = w_close ? StIdle : StFill;
    end

    w_flat = '0;
    for (int unsigned n = 0; n < LANES; n++) begin
      w_flat[n*DATA_W +: DATA_W] = w_buf_nxt[n];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_max         <= '0;
      r_mode        <= '0;
      for (int unsigned n = 0; n < LANES; n++) begin
        r_buf[n] <= PAD;
      end
      o_valid       <= 1'b0;
      o_overflow    <= 1'b0;
      o_x_flat      <= '0;
      o_length_mode <= '0;
      o_row_len     <= '0;
      o_row_max     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      o_valid    <= w_emit;
      o_overflow <= w_emit && w_ovf;
      if (w_accept) begin
        if (w_close) begin
          // Clearing here lets the next row start in the same cycle the row emits
          r_cnt <= '0;
          r_max <= '0;
          for (int unsigned n = 0; n < LANES; n++) begin
            r_buf[n] <= PAD;
          end
        end else begin
          r_cnt  <= w_cnt_nxt;
          r_max  <= w_max_nxt;
          r_mode <= w_mode;
          r_buf  <= w_buf_nxt;
        end
      end
      if (w_emit) begin
        o_x_flat      <= w_flat;
        o_length_mode <= w_mode;
        o_row_len     <= w_cnt_nxt;
        o_row_max     <= w_max_nxt;
      end
    end
  end

endmodule

// File: tb/tb_softmax_row_gather.sv
// Bench for softmax_row_gather: directed beats feed a scoreboard of expected rows,
// compared field by field (including emission cycle) whenever o_valid is seen.
module tb_softmax_row_gather;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_en;
  logic          i_valid;
  logic          o_ready;
  logic [63:0]   i_data;
  logic [3:0]    i_keep;
  logic          i_last;
  logic [3:0]    i_length_mode;
  logic          o_valid;
  logic [1023:0] o_x_flat;
  logic [3:0]    o_length_mode;
  logic [6:0]    o_row_len;
  logic [15:0]   o_row_max;
  logic          o_overflow;

  softmax_row_gather dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_en          (i_en),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_data        (i_data),
    .i_keep        (i_keep),
    .i_last        (i_last),
    .i_length_mode (i_length_mode),
    .o_valid       (o_valid),
    .o_x_flat      (o_x_flat),
    .o_length_mode (o_length_mode),
    .o_row_len     (o_row_len),
    .o_row_max     (o_row_max),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [1023:0] x;
    logic [3:0]    mode;
    logic [6:0]    len;
    logic [15:0]   max;
    logic          ovf;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  k;
    logic [3:0]  m;
    int          len;
    logic [15:0] mx;
  } vec_t;

  exp_t        sb [$];
  exp_t        got;
  vec_t        vecs [9];
  logic [15:0] row_l [64];
  logic [15:0] v [4];
  int          n;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [63:0] mk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_x(input string nm, input logic [1023:0] act, input logic [1023:0] req);
    int bad;
    checks++;
    if (act !== req) begin
      failures++;
      bad = 0;
      for (int i = 63; i >= 0; i--) if (act[16*i +: 16] !== req[16*i +: 16]) bad = i;
      $display("FAIL %s lane=%0d actual=%0h required=%0h", nm, bad,
               act[16*bad +: 16], req[16*bad +: 16]);
    end
  endtask

  task automatic expect_row(input logic [3:0] m, input int len, input logic [15:0] mx,
                            input logic ov, input int dcyc);
    exp_t r;
    r.x = '0;
    for (int i = 0; i < 64; i++) r.x[16*i +: 16] = (i < len) ? row_l[i] : 16'h8000;
    r.mode = m;
    r.len  = 7'(len);
    r.max  = mx;
    r.ovf  = ov;
    r.cyc  = cyc + dcyc;
    sb.push_back(r);
  endtask

  task automatic beat(input logic [63:0] d, input logic [3:0] k, input logic l,
                      input logic [3:0] m);
    i_valid = 1'b1;
    i_data = d;
    i_keep = k;
    i_last = l;
    i_length_mode = m;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_keep = 4'h0;
    i_last = 1'b0;
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_overflow && !o_valid) chk("overflow_without_valid", 32'(o_overflow), 32'd0);
      if (o_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'(o_valid), 32'd0);
        end else begin
          got = sb.pop_front();
          chk("row_cycle", 32'(cyc), 32'(got.cyc));
          chk_x("row_x", o_x_flat, got.x);
          chk("row_mode", 32'(o_length_mode), 32'(got.mode));
          chk("row_len", 32'(o_row_len), 32'(got.len));
          chk("row_max", 32'(o_row_max), 32'(got.max));
          chk("row_overflow", 32'(o_overflow), 32'(got.ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{mk(16'h0001, 16'h0002, 16'h0003, 16'h0004), 4'hF, 4'd0, 4, 16'h0004};
    vecs[1] = '{mk(16'hFFFF, 16'h8001, 16'hFFFE, 16'h8000), 4'hF, 4'd1, 4, 16'hFFFF};
    vecs[2] = '{mk(16'h7FFF, 16'h0000, 16'h8000, 16'h0001), 4'hF, 4'd2, 4, 16'h7FFF};
    vecs[3] = '{mk(16'h0B26, 16'hF5BE, 16'h0B25, 16'h0000), 4'hF, 4'd3, 4, 16'h0B26};
    vecs[4] = '{mk(16'h8000, 16'h8000, 16'h8000, 16'h8000), 4'hF, 4'd4, 4, 16'h8000};
    vecs[5] = '{mk(16'hFFF0, 16'h0010, 16'hFFF1, 16'h000F), 4'hF, 4'd5, 4, 16'h0010};
    vecs[6] = '{mk(16'h0005, 16'h7FFF, 16'h7FFF, 16'h7FFF), 4'h1, 4'd6, 1, 16'h0005};
    vecs[7] = '{mk(16'hFFF0, 16'hFFF8, 16'hFFF4, 16'h7FFF), 4'h7, 4'd7, 3, 16'hFFF8};
    vecs[8] = '{mk(16'h0002, 16'h0003, 16'h7FFF, 16'h7FFF), 4'h3, 4'd8, 2, 16'h0003};

    i_rst_n = 1'b0;
    i_en = 1'b1;
    i_valid = 1'b0;
    i_data = '0;
    i_keep = 4'h0;
    i_last = 1'b0;
    i_length_mode = 4'h0;
    #12;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_overflow", 32'(o_overflow), 32'd0);
    chk_x("rst_x", o_x_flat, '0);
    chk("rst_len", 32'(o_row_len), 32'd0);
    chk("rst_max", 32'(o_row_max), 32'd0);
    chk("rst_mode", 32'(o_length_mode), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Four full beats, lanes 0x0001..0x0010, first beat right after reset release
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) begin
        v[k] = 16'(b*4 + k + 1);
        row_l[b*4 + k] = v[k];
      end
      if (b == 3) expect_row(4'd0, 16, 16'h0010, 1'b0, 1);
      beat({v[3], v[2], v[1], v[0]}, 4'hF, b == 3, 4'd0);
    end
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("hold_len", 32'(o_row_len), 32'd16);
    chk("hold_max", 32'(o_row_max), 32'h0010);
    chk("hold_lane15", 32'(o_x_flat[16*15 +: 16]), 32'h0010);
    chk("hold_lane16", 32'(o_x_flat[16*16 +: 16]), 32'h8000);
    @(posedge i_clk);
    #1;

    // Partial second beat; unkept upper lanes must not reach the max
    row_l[0] = 16'h0100; row_l[1] = 16'hF5BE; row_l[2] = 16'h0200; row_l[3] = 16'h0010;
    row_l[4] = 16'h0B26; row_l[5] = 16'h0003;
    beat(mk(16'h0100, 16'hF5BE, 16'h0200, 16'h0010), 4'hF, 1'b0, 4'd5);
    expect_row(4'd5, 6, 16'h0B26, 1'b0, 1);
    beat(mk(16'h0B26, 16'h0003, 16'h7FFF, 16'h7FFF), 4'h3, 1'b1, 4'd9);

    // Back-to-back single-beat rows from the table
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 4; k++) row_l[k] = vecs[i].d[16*k +: 16];
      expect_row(vecs[i].m, vecs[i].len, vecs[i].mx, 1'b0, 1);
      beat(vecs[i].d, vecs[i].k, 1'b1, vecs[i].m);
    end

    // Sixteen full beats without last: forced close, then a fresh 4-lane row
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 4; k++) begin
        n = b*4 + k;
        v[k] = (n == 40) ? 16'h7123 : (n == 10) ? 16'hFFFF : 16'(16'h0100 + n);
        row_l[n] = v[k];
      end
      if (b == 15) expect_row(4'd7, 64, 16'h7123, 1'b1, 1);
      beat({v[3], v[2], v[1], v[0]}, 4'hF, 1'b0, (b == 0) ? 4'd7 : 4'd0);
    end
    for (int k = 0; k < 4; k++) row_l[k] = 16'(k + 1);
    expect_row(4'd9, 4, 16'h0004, 1'b0, 1);
    beat(mk(16'h0001, 16'h0002, 16'h0003, 16'h0004), 4'hF, 1'b1, 4'd9);

    // Last beat landing exactly on lane 63 is a normal close
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 4; k++) begin
        v[k] = 16'(b*4 + k);
        row_l[b*4 + k] = v[k];
      end
      if (b == 15) expect_row(4'd6, 64, 16'h003F, 1'b0, 1);
      beat({v[3], v[2], v[1], v[0]}, 4'hF, b == 15, (b == 0) ? 4'd6 : 4'd1);
    end

    // Overflow mid-beat: the two lanes past lane 63 are dropped
    row_l[0] = 16'h0001; row_l[1] = 16'h0002;
    beat(mk(16'h0001, 16'h0002, 16'h7FFF, 16'h7FFF), 4'h3, 1'b0, 4'd10);
    for (int b = 0; b < 15; b++) begin
      for (int k = 0; k < 4; k++) begin
        n = 2 + b*4 + k;
        v[k] = 16'(16'h0010 + n);
        row_l[n] = v[k];
      end
      beat({v[3], v[2], v[1], v[0]}, 4'hF, 1'b0, 4'd0);
    end
    row_l[62] = 16'h0050; row_l[63] = 16'h0051;
    expect_row(4'd10, 64, 16'h0051, 1'b1, 1);
    beat(mk(16'h0050, 16'h0051, 16'h7FFF, 16'h7FFE), 4'hF, 1'b0, 4'd0);
    row_l[0] = 16'h0007;
    expect_row(4'd3, 1, 16'h0007, 1'b0, 1);
    beat(mk(16'h0007, 16'h7FFF, 16'h0000, 16'h0000), 4'h1, 1'b1, 4'd3);

    // Enable low for three cycles mid-row delays emission by exactly three cycles
    for (int i = 0; i < 16; i++) row_l[i] = 16'(i + 1);
    expect_row(4'd0, 16, 16'h0010, 1'b0, 7);
    beat(mk(16'h0001, 16'h0002, 16'h0003, 16'h0004), 4'hF, 1'b0, 4'd0);
    beat(mk(16'h0005, 16'h0006, 16'h0007, 16'h0008), 4'hF, 1'b0, 4'd0);
    i_en = 1'b0;
    i_valid = 1'b1;
    i_data = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    i_keep = 4'hF;
    i_last = 1'b1;
    #1;
    chk("ready_en_low", 32'(o_ready), 32'd0);
    repeat (3) @(posedge i_clk);
    #1;
    i_en = 1'b1;
    i_valid = 1'b0;
    beat(mk(16'h0009, 16'h000A, 16'h000B, 16'h000C), 4'hF, 1'b0, 4'd0);
    beat(mk(16'h000D, 16'h000E, 16'h000F, 16'h0010), 4'hF, 1'b1, 4'd0);

    // Empty beats: keep=0 no-op, keep=0 with last closes, and nothing when row is empty
    for (int k = 0; k < 4; k++) row_l[k] = 16'(16'h000A + k);
    beat(mk(16'h000A, 16'h000B, 16'h000C, 16'h000D), 4'hF, 1'b0, 4'd2);
    beat(mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 4'h0, 1'b0, 4'd0);
    expect_row(4'd2, 4, 16'h000D, 1'b0, 1);
    beat(mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 4'h0, 1'b1, 4'd0);
    beat(mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 4'h0, 1'b1, 4'd4);

    // Reset mid-row discards the partial row and clears the outputs
    beat(mk(16'h7000, 16'h7001, 16'h7002, 16'h7003), 4'hF, 1'b0, 4'd1);
    beat(mk(16'h7004, 16'h7005, 16'h7006, 16'h7007), 4'hF, 1'b0, 4'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk_x("midrst_x", o_x_flat, '0);
    chk("midrst_len", 32'(o_row_len), 32'd0);
    chk("midrst_max", 32'(o_row_max), 32'd0);
    chk("midrst_mode", 32'(o_length_mode), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    for (int k = 0; k < 4; k++) row_l[k] = 16'(16'h0020 + k);
    expect_row(4'd2, 4, 16'h0023, 1'b0, 1);
    beat(mk(16'h0020, 16'h0021, 16'h0022, 16'h0023), 4'hF, 1'b1, 4'd2);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge i_clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (4) @(posedge i_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
